game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter BRICK_COUNT, default 512: number of brick-array entries cleared per level (64 x 8).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frames the ball is held before play starts.
REQ-003 SHALL have parameter OVER_FRAMES, default 180: frames spent in game-over before returning to idle.
REQ-004 SHALL have port clk_x5  in  1  125 MHz system clock; the only clock.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port pix_en  in  1  one-cycle enable every 5th clk_x5 cycle (pixel rate).
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse at vc==vfp, hc==0.
REQ-008 SHALL have port start_btn  in  1  synchronous start request, level.
REQ-009 SHALL have port ball_lost  in  1  one-cycle pulse: ball passed the bottom border.
REQ-010 SHALL have port bricks_zero  in  1  level: no bricks remain.
REQ-011 SHALL have port lives  in  4  current lives from player_stats.
REQ-012 SHALL have port state  out  3  current state encoding.
REQ-013 SHALL have port ball_run  out  1  level: enables ball motion.
REQ-014 SHALL have port ball_reset  out  1  one-cycle pulse: load serve position.
REQ-015 SHALL have port declives  out  1  one-cycle pulse: decrement lives.
REQ-016 SHALL have port stats_reset  out  1  one-cycle pulse: reset score and lives.
REQ-017 SHALL have ports brick_clr_we  out  1, brick_clr_addr  out  9, brick_clr_busy  out  1: brick-array clear write port and busy flag.

Function
REQ-018 SHALL implement states IDLE=0, CLEAR=1, SERVE=2, PLAY=3, LOST=4, OVER=5; codes 6-7 SHALL return to IDLE on the next cycle.
REQ-019 IDLE: start_btn high SHALL enter CLEAR and pulse stats_reset in the same transition cycle.
REQ-020 CLEAR: on each pix_en cycle SHALL assert brick_clr_we with brick_clr_addr counting 0..BRICK_COUNT-1; brick_clr_busy high throughout; after the last write SHALL enter SERVE, pulse ball_reset, and reset the address to 0.
REQ-021 SERVE: ball_run low; SHALL count frame_tick pulses and enter PLAY on the SERVE_FRAMES-th.
REQ-022 PLAY: ball_run high; ball_lost SHALL enter LOST and pulse declives; otherwise bricks_zero high SHALL enter CLEAR (next level, no stats_reset).
REQ-023 ball_lost and bricks_zero in the same cycle: ball_lost SHALL win.
REQ-024 LOST: ball_run low; at the next frame_tick, lives==0 SHALL enter OVER, else SHALL enter SERVE with a ball_reset pulse.
REQ-025 OVER: SHALL count OVER_FRAMES frame_ticks, then enter IDLE; start_btn SHALL be ignored until then.
REQ-026 Frame counter SHALL be 8 bits, cleared on every state entry, and SHALL never wrap (saturate at 255).
REQ-027 All outputs SHALL be registered; the latency from input event to output SHALL be 1 clk_x5 cycle.

Reset
REQ-028 resetn low SHALL force state IDLE, all pulses, ball_run, brick_clr_we and brick_clr_busy to 0, and the address and counters to 0.
REQ-029 Reset during CLEAR SHALL abort the sweep; the next start SHALL restart at address 0.

Configuration
REQ-030 Macro GAME_SEQ_ATTRACT_EN defined: IDLE SHALL drive ball_run=1 (attract-mode demo bounce). Undefined: ball_run=0 in IDLE. All other behaviour SHALL be identical.

Structure
REQ-031 Package game_pkg SHALL hold the state encoding, BRICKS_H=64, BRICKS_V=8, and the default frame counts.
REQ-032 SHALL contain one sub-module, frame_timer: a loadable, saturating frame_tick counter with a done flag.

Verification
REQ-033 Reset, then start_btn high for 1 cycle -> stats_reset pulses once; exactly 512 brick_clr_we writes at pix_en cycles, addresses 0..511; then ball_reset pulses and state==2.
REQ-034 In SERVE, apply 60 frame_ticks -> state==3 and ball_run==1 one cycle after the 60th tick, not before.
REQ-035 In PLAY with lives==2, pulse ball_lost -> declives pulse and state==4; at the next frame_tick -> state==2 with a ball_reset pulse.
REQ-036 In PLAY with lives==0 after the decrement, pulse ball_lost -> OVER; start_btn ignored for 180 ticks; then IDLE.
REQ-037 In PLAY, assert ball_lost and bricks_zero together -> state==4, not CLEAR.
REQ-038 Assert resetn low at address 200 of CLEAR -> outputs 0, state==0; after restart the sweep begins at 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encoding, playfield dimensions and default frame counts for
// the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SERVE = 3'd2,
        ST_PLAY  = 3'd3,
        ST_LOST  = 3'd4,
        ST_OVER  = 3'd5
    } game_state_e;

    localparam int BRICKS_H         = 64;
    localparam int BRICKS_V         = 8;
    localparam int BRICK_COUNT_DEF  = BRICKS_H * BRICKS_V;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int OVER_FRAMES_DEF  = 180;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable, saturating frame_tick counter; done flags the tick that brings
// the count up to the target.
module frame_timer
    import game_pkg::*;
(
    input  logic       clk_x5,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    input  logic [7:0] target,
    output logic       done
);

    logic [7:0] count_r;

    // Frame count register: a load takes priority over a tick.
    always_ff @(posedge clk_x5 or negedge resetn) begin
        if (!resetn) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (tick) begin
            count_r <= sat_inc8(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    // Done decode; independent of load so the parent FSM sees no loop.
    always_comb begin
        done = 1'b0;
        if (tick && (sat_inc8(count_r) >= target)) begin
            done = 1'b1;
        end else begin
            done = 1'b0;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow FSM: idle, brick clear sweep, serve, play, lost, over.
// Define GAME_SEQ_ATTRACT_EN to keep the ball bouncing while idle.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BRICK_COUNT  = BRICK_COUNT_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int OVER_FRAMES  = OVER_FRAMES_DEF
)(
    input  logic       clk_x5,
    input  logic       resetn,
    input  logic       pix_en,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       ball_lost,
    input  logic       bricks_zero,
    input  logic [3:0] lives,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       declives,
    output logic       stats_reset,
    output logic       brick_clr_we,
    output logic [8:0] brick_clr_addr,
    output logic       brick_clr_busy
);

    localparam logic [8:0] LAST_ADDR = 9'(BRICK_COUNT - 1);
    localparam logic [7:0] SERVE_TGT = 8'(SERVE_FRAMES);
    localparam logic [7:0] OVER_TGT  = 8'(OVER_FRAMES);
`ifdef GAME_SEQ_ATTRACT_EN
    localparam logic IDLE_RUN = 1'b1;
`else
    localparam logic IDLE_RUN = 1'b0;
`endif

    game_state_e state_r, next_s;
    logic        ball_run_r, ball_reset_r, declives_r, stats_reset_r;
    logic        clr_we_r, clr_busy_r;
    logic [8:0]  clr_addr_r;
    logic        ball_run_s, ball_reset_s, declives_s, stats_reset_s, clr_we_s;
    logic        frame_load_s, frame_done_s;
    logic [7:0]  frame_tgt_s;

    frame_timer u_frame_timer (
        .clk_x5   (clk_x5),
        .resetn   (resetn),
        .load     (frame_load_s),
        .load_val (8'd0),
        .tick     (frame_tick),
        .target   (frame_tgt_s),
        .done     (frame_done_s)
    );

    // Counter restarts on every state change; OVER uses the longer target.
    assign frame_load_s = (next_s != state_r);

    // Frame target selection.
    always_comb begin
        frame_tgt_s = SERVE_TGT;
        if (state_r == ST_OVER) begin
            frame_tgt_s = OVER_TGT;
        end else begin
            frame_tgt_s = SERVE_TGT;
        end
    end

    // Next-state and next-pulse decode.
    always_comb begin
        next_s        = state_r;
        ball_reset_s  = 1'b0;
        declives_s    = 1'b0;
        stats_reset_s = 1'b0;
        clr_we_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_btn) begin
                    next_s        = ST_CLEAR;
                    stats_reset_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // The final write is already on the port; leave once it retires.
                if (clr_we_r && (clr_addr_r == LAST_ADDR)) begin
                    next_s       = ST_SERVE;
                    ball_reset_s = 1'b1;
                end else begin
                    clr_we_s = pix_en;
                end
            end
            ST_SERVE: begin
                if (frame_done_s) next_s = ST_PLAY;
                else              next_s = ST_SERVE;
            end
            ST_PLAY: begin
                if (ball_lost) begin
                    next_s     = ST_LOST;
                    declives_s = 1'b1;
                end else if (bricks_zero) begin
                    next_s = ST_CLEAR;
                end else begin
                    next_s = ST_PLAY;
                end
            end
            ST_LOST: begin
                if (frame_tick) begin
                    if (lives == 4'd0) begin
                        next_s = ST_OVER;
                    end else begin
                        next_s       = ST_SERVE;
                        ball_reset_s = 1'b1;
                    end
                end else begin
                    next_s = ST_LOST;
                end
            end
            ST_OVER: begin
                if (frame_done_s) next_s = ST_IDLE;
                else              next_s = ST_OVER;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
        ball_run_s = (next_s == ST_PLAY) || ((next_s == ST_IDLE) && IDLE_RUN);
    end

    // State and registered output flops.
    always_ff @(posedge clk_x5 or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            ball_run_r    <= 1'b0;
            ball_reset_r  <= 1'b0;
            declives_r    <= 1'b0;
            stats_reset_r <= 1'b0;
            clr_we_r      <= 1'b0;
            clr_busy_r    <= 1'b0;
        end else begin
            state_r       <= next_s;
            ball_run_r    <= ball_run_s;
            ball_reset_r  <= ball_reset_s;
            declives_r    <= declives_s;
            stats_reset_r <= stats_reset_s;
            clr_we_r      <= clr_we_s;
            clr_busy_r    <= (next_s == ST_CLEAR);
        end
    end

    // Sweep address: advances after each write, held at 0 outside a sweep.
    always_ff @(posedge clk_x5 or negedge resetn) begin
        if (!resetn) begin
            clr_addr_r <= 9'd0;
        end else if ((state_r != ST_CLEAR) || (next_s != ST_CLEAR)) begin
            clr_addr_r <= 9'd0;
        end else if (clr_we_r) begin
            clr_addr_r <= clr_addr_r + 9'd1;
        end else begin
            clr_addr_r <= clr_addr_r;
        end
    end

    assign state          = state_r;
    assign ball_run       = ball_run_r;
    assign ball_reset     = ball_reset_r;
    assign declives       = declives_r;
    assign stats_reset    = stats_reset_r;
    assign brick_clr_we   = clr_we_r;
    assign brick_clr_addr = clr_addr_r;
    assign brick_clr_busy = clr_busy_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: vector table, directed corner
// sequences and random stimulus against a behavioural model.
module tb_game_sequencer;

    localparam int BC = 512;
    localparam int SF = 60;
    localparam int OF = 180;
`ifdef GAME_SEQ_ATTRACT_EN
    localparam bit ATTRACT = 1'b1;
`else
    localparam bit ATTRACT = 1'b0;
`endif

    logic       clk_x5 = 1'b0;
    logic       resetn = 1'b0;
    logic       pix_en = 1'b0, frame_tick = 1'b0, start_btn = 1'b0;
    logic       ball_lost = 1'b0, bricks_zero = 1'b0;
    logic [3:0] lives = 4'd2;
    logic [2:0] state;
    logic       ball_run, ball_reset, declives, stats_reset;
    logic       brick_clr_we, brick_clr_busy;
    logic [8:0] brick_clr_addr;

    always #4 clk_x5 = ~clk_x5;

    game_sequencer dut (
        .clk_x5(clk_x5), .resetn(resetn), .pix_en(pix_en), .frame_tick(frame_tick),
        .start_btn(start_btn), .ball_lost(ball_lost), .bricks_zero(bricks_zero),
        .lives(lives), .state(state), .ball_run(ball_run), .ball_reset(ball_reset),
        .declives(declives), .stats_reset(stats_reset), .brick_clr_we(brick_clr_we),
        .brick_clr_addr(brick_clr_addr), .brick_clr_busy(brick_clr_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: mode 0 idle, 1 clear, 2 serve, 3 play, 4 lost, 5 over.
    int m_st = 0, m_frames = 0, m_written = 0, m_addr = 0;
    bit m_run = 0, m_brst = 0, m_dec = 0, m_srst = 0, m_we = 0, m_busy = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_update();
        int prev;
        m_brst = 1'b0; m_dec = 1'b0; m_srst = 1'b0; m_we = 1'b0;
        if (!resetn) begin
            m_st = 0; m_frames = 0; m_written = 0; m_addr = 0;
            m_run = 1'b0; m_busy = 1'b0;
        end else begin
            prev = m_st;
            case (m_st)
                0: if (start_btn) begin m_st = 1; m_srst = 1'b1; end
                1: begin
                    if (m_written == BC) begin
                        m_st = 2; m_brst = 1'b1;
                    end else if (pix_en) begin
                        m_we = 1'b1; m_addr = m_written; m_written++;
                    end
                end
                2: if (frame_tick) begin
                    m_frames = (m_frames < 255) ? m_frames + 1 : 255;
                    if (m_frames == SF) m_st = 3;
                end
                3: begin
                    if (ball_lost) begin m_st = 4; m_dec = 1'b1; end
                    else if (bricks_zero) m_st = 1;
                end
                4: if (frame_tick) begin
                    if (lives == 4'd0) m_st = 5;
                    else begin m_st = 2; m_brst = 1'b1; end
                end
                5: if (frame_tick) begin
                    m_frames = (m_frames < 255) ? m_frames + 1 : 255;
                    if (m_frames == OF) m_st = 0;
                end
                default: m_st = 0;
            endcase
            if (m_st != prev) begin m_frames = 0; m_written = 0; end
            if (m_st != 1) m_addr = 0;
            m_run  = (m_st == 3) || (ATTRACT && (m_st == 0));
            m_busy = (m_st == 1);
        end
    endtask

    task automatic step();
        @(posedge clk_x5);
        model_update();
        @(negedge clk_x5);
        cyc++;
        chk("model_outputs",
            32'({state, ball_run, ball_reset, declives, stats_reset, brick_clr_we, brick_clr_busy}),
            32'({3'(m_st), m_run, m_brst, m_dec, m_srst, m_we, m_busy}));
        if (m_we || (m_st != 1)) chk("model_addr", 32'(brick_clr_addr), 32'(m_addr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    typedef struct {
        bit         rstn, start, pix, tick;
        logic [2:0] e_state;
        bit         e_srst, e_we, e_busy, chk_addr;
        logic [8:0] e_addr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int writes, addr_bad, srst_cnt, guard;
        bit seen_brst, hit;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 9'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd2};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 9'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 9'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0};

        @(negedge clk_x5);
        for (int i = 0; i < 12; i++) begin
            resetn = tbl[i].rstn; start_btn = tbl[i].start;
            pix_en = tbl[i].pix;  frame_tick = tbl[i].tick;
            step();
            chk($sformatf("table_%0d", i),
                32'({state, stats_reset, brick_clr_we, brick_clr_busy}),
                32'({tbl[i].e_state, tbl[i].e_srst, tbl[i].e_we, tbl[i].e_busy}));
            if (tbl[i].chk_addr) chk($sformatf("table_addr_%0d", i), 32'(brick_clr_addr), 32'(tbl[i].e_addr));
        end
        start_btn = 1'b0; pix_en = 1'b0; frame_tick = 1'b0;

        // Full first-level sweep from a fresh start.
        resetn = 1'b1; step();
        start_btn = 1'b1; step();
        srst_cnt = stats_reset ? 1 : 0;
        start_btn = 1'b0;
        writes = 0; addr_bad = 0; seen_brst = 1'b0;
        for (guard = 0; guard < 4000 && !seen_brst; guard++) begin
            pix_en = (cyc % 5 == 0);
            step();
            if (brick_clr_we) begin
                if (brick_clr_addr !== 9'(writes)) addr_bad++;
                writes++;
            end
            if (stats_reset) srst_cnt++;
            if (ball_reset) seen_brst = 1'b1;
        end
        pix_en = 1'b0;
        chk("sweep_ball_reset_seen", 32'(seen_brst), 32'd1);
        chk("sweep_writes", 32'(writes), 32'd512);
        chk("sweep_addr_order_errors", 32'(addr_bad), 32'd0);
        chk("sweep_stats_reset_count", 32'(srst_cnt), 32'd1);
        chk("sweep_end_state", 32'(state), 32'd2);

        // Serve: play starts exactly on the 60th tick.
        ticks(SF - 1);
        chk("serve_59_state", 32'(state), 32'd2);
        chk("serve_59_run", 32'(ball_run), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("serve_60_state", 32'(state), 32'd3);
        chk("serve_60_run", 32'(ball_run), 32'd1);

        // Ball lost with lives remaining.
        lives = 4'd2;
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("lost_declives", 32'(declives), 32'd1);
        chk("lost_state", 32'(state), 32'd4);
        chk("lost_run", 32'(ball_run), 32'd0);
        step();
        chk("lost_declives_single", 32'(declives), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("lost_to_serve_state", 32'(state), 32'd2);
        chk("lost_to_serve_ball_reset", 32'(ball_reset), 32'd1);

        // Simultaneous ball_lost and bricks_zero.
        ticks(SF);
        chk("replay_state", 32'(state), 32'd3);
        ball_lost = 1'b1; bricks_zero = 1'b1; step();
        ball_lost = 1'b0; bricks_zero = 1'b0;
        chk("lost_beats_bricks_state", 32'(state), 32'd4);
        chk("lost_beats_bricks_busy", 32'(brick_clr_busy), 32'd0);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        ticks(SF);

        // Last life: game over holds off start for 180 ticks.
        lives = 4'd0;
        ball_lost = 1'b1; step(); ball_lost = 1'b0;
        chk("last_life_state", 32'(state), 32'd4);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("over_entry_state", 32'(state), 32'd5);
        start_btn = 1'b1;
        ticks(OF - 1);
        chk("over_holds_state", 32'(state), 32'd5);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("over_to_idle_state", 32'(state), 32'd0);
        start_btn = 1'b0; step();
        chk("idle_after_over", 32'(state), 32'd0);
        chk("idle_after_over_run", 32'(ball_run), 32'(ATTRACT));

        // Reset at address 200 aborts the sweep; restart begins at 0.
        lives = 4'd3;
        start_btn = 1'b1; step(); start_btn = 1'b0;
        hit = 1'b0;
        for (guard = 0; guard < 2000 && !hit; guard++) begin
            pix_en = (cyc % 5 == 0);
            step();
            if (brick_clr_we && brick_clr_addr == 9'd200) hit = 1'b1;
        end
        pix_en = 1'b0;
        chk("abort_reached_200", 32'(hit), 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_outputs_zero",
            32'({state, ball_run, ball_reset, declives, stats_reset, brick_clr_we, brick_clr_busy, brick_clr_addr}),
            32'd0);
        step();
        resetn = 1'b1; step();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        hit = 1'b0;
        for (guard = 0; guard < 20 && !hit; guard++) begin
            pix_en = (cyc % 5 == 0);
            step();
            if (brick_clr_we) begin
                hit = 1'b1;
                chk("restart_first_addr", 32'(brick_clr_addr), 32'd0);
            end
        end
        chk("restart_write_seen", 32'(hit), 32'd1);

        // Random play against the model.
        for (int i = 0; i < 20000; i++) begin
            resetn      = ($urandom_range(3999, 0) != 0);
            start_btn   = ($urandom_range(49, 0) == 0);
            pix_en      = (cyc % 5 == 0);
            frame_tick  = ($urandom_range(7, 0) == 0);
            ball_lost   = ($urandom_range(39, 0) == 0);
            bricks_zero = ($urandom_range(99, 0) == 0);
            if ($urandom_range(63, 0) == 0) lives = 4'($urandom_range(3, 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
